// File: rtl/fpu_denormalise.sv
// Float (single/double) to 32/64-bit integer conversion: unpack, align, then round and saturate.
// Handshake: adv = !valid_o | ready_i moves all three stages at once; ready_o = adv.
module fpu_denormalise (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        valid_i,
  output logic        ready_o,
  input  logic [63:0] fp_in,
  input  logic        fp_fmt,
  input  logic [1:0]  int_fmt,
  input  logic [4:0]  fpu_op,
  input  logic [2:0]  rm,
  output logic        valid_o,
  input  logic        ready_i,
  output logic [63:0] int_out,
  output logic [4:0]  fflags
);

  logic adv;

  // Stage 1: unpack
  logic               s1_valid_q, s1_sign_q, s1_nan_q, s1_inf_q, s1_zero_q;
  logic               s1_int64_q, s1_uns_q;
  logic [2:0]         s1_rm_q;
  logic signed [11:0] s1_exp_q;
  logic [52:0]        s1_man_q;
  logic               s1_sign_d, s1_nan_d, s1_inf_d, s1_zero_d;
  logic signed [11:0] s1_exp_d;
  logic [52:0]        s1_man_d;

  // Stage 2: align
  logic        s2_valid_q, s2_sign_q, s2_nan_q, s2_inf_q, s2_ovf_q, s2_g_q, s2_s_q;
  logic        s2_int64_q, s2_uns_q;
  logic [2:0]  s2_rm_q;
  logic [63:0] s2_mag_q;
  logic        s2_ovf_d, s2_g_d, s2_s_d;
  logic [63:0] s2_mag_d;
  logic [3:0]  lsh;
  logic [6:0]  rsh;
  logic [127:0] rshifted;

  // Stage 3: round / saturate
  logic        valid_o_q;
  logic [63:0] int_out_q, int_out_d, res;
  logic [4:0]  fflags_q, fflags_d;
  logic        inc, nv, nx;
  logic [64:0] rounded, lim_pos, lim_neg;
  logic [63:0] max_val, min_val;

  logic unused_bits;
  assign unused_bits = ^{int_fmt[1], fpu_op[3:0]};

  assign adv     = !valid_o_q || ready_i;
  assign ready_o = adv;
  assign valid_o = valid_o_q;
  assign int_out = int_out_q;
  assign fflags  = fflags_q;

  always_comb begin
    s1_sign_d = fp_in[31];
    s1_exp_d  = '0;
    s1_man_d  = '0;
    s1_nan_d  = 1'b0;
    s1_inf_d  = 1'b0;
    s1_zero_d = 1'b0;
    if (fp_fmt) begin
      s1_sign_d = fp_in[63];
      s1_man_d  = {|fp_in[62:52], fp_in[51:0]};
      s1_exp_d  = (|fp_in[62:52]) ? ($signed({1'b0, fp_in[62:52]}) - 12'sd1023) : -12'sd1022;
      s1_nan_d  = (&fp_in[62:52]) && (|fp_in[51:0]);
      s1_inf_d  = (&fp_in[62:52]) && !(|fp_in[51:0]);
      s1_zero_d = !(|fp_in[62:0]);
    end else begin
      // Single significand is left-aligned so both formats share one 53-bit datapath
      s1_man_d  = {|fp_in[30:23], fp_in[22:0], 29'b0};
      s1_exp_d  = (|fp_in[30:23]) ? ($signed({4'b0, fp_in[30:23]}) - 12'sd127) : -12'sd126;
      s1_nan_d  = (&fp_in[30:23]) && (|fp_in[22:0]);
      s1_inf_d  = (&fp_in[30:23]) && !(|fp_in[22:0]);
      s1_zero_d = !(|fp_in[30:0]);
    end
  end

  always_comb begin
    lsh      = 4'(s1_exp_q - 12'sd52);
    rsh      = 7'(12'sd52 - s1_exp_q);
    rshifted = {11'b0, s1_man_q, 64'b0} >> rsh;
    s2_ovf_d = 1'b0;
    s2_mag_d = '0;
    s2_g_d   = 1'b0;
    s2_s_d   = 1'b0;
    if (!(s1_nan_q || s1_inf_q || s1_zero_q)) begin
      if (s1_exp_q >= 12'sd64) begin
        s2_ovf_d = 1'b1;
      end else if (s1_exp_q >= 12'sd52) begin
        s2_mag_d = {11'b0, s1_man_q} << lsh;
      end else if (s1_exp_q >= -12'sd2) begin
        s2_mag_d = rshifted[127:64];
        s2_g_d   = rshifted[63];
        s2_s_d   = |rshifted[62:0];
      end else begin
        s2_s_d   = |s1_man_q;
      end
    end
  end

  always_comb begin
    case (s2_rm_q)
      3'b000:  inc = s2_g_q && (s2_s_q || s2_mag_q[0]);
      3'b010:  inc = s2_sign_q && (s2_g_q || s2_s_q);
      3'b011:  inc = !s2_sign_q && (s2_g_q || s2_s_q);
      3'b100:  inc = s2_g_q;
      default: inc = 1'b0;
    endcase
    // 65 bits so a carry out of an all-ones magnitude still reads as overflow
    rounded = {1'b0, s2_mag_q} + {64'b0, inc};
    if (s2_uns_q) lim_pos = s2_int64_q ? {1'b0, {64{1'b1}}} : {33'b0, {32{1'b1}}};
    else          lim_pos = s2_int64_q ? {2'b0, {63{1'b1}}} : {34'b0, {31{1'b1}}};
    lim_neg = s2_int64_q ? {2'b01, 63'b0} : {33'b0, 1'b1, 31'b0};
    if (s2_uns_q) max_val = {64{1'b1}};
    else          max_val = s2_int64_q ? 64'h7FFF_FFFF_FFFF_FFFF : 64'h0000_0000_7FFF_FFFF;
    if (s2_uns_q) min_val = '0;
    else          min_val = s2_int64_q ? 64'h8000_0000_0000_0000 : 64'hFFFF_FFFF_8000_0000;
    res = '0;
    nv  = 1'b0;
    nx  = 1'b0;
    if (s2_nan_q) begin
      res = max_val;
      nv  = 1'b1;
    end else if (s2_inf_q) begin
      res = s2_sign_q ? min_val : max_val;
      nv  = 1'b1;
    end else if (!s2_sign_q) begin
      if (s2_ovf_q || rounded > lim_pos) begin
        res = max_val;
        nv  = 1'b1;
      end else begin
        res = rounded[63:0];
        nx  = s2_g_q || s2_s_q;
      end
    end else if (s2_uns_q) begin
      if (s2_ovf_q || rounded != 65'd0) nv = 1'b1;
      else                              nx = s2_g_q || s2_s_q;
    end else if (s2_ovf_q || rounded > lim_neg) begin
      res = min_val;
      nv  = 1'b1;
    end else begin
      res = -rounded[63:0];
      nx  = s2_g_q || s2_s_q;
    end
    int_out_d = s2_int64_q ? res : {{32{res[31]}}, res[31:0]};
    fflags_d  = {nv, 3'b000, nx};
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_valid_q <= 1'b0; s1_sign_q <= 1'b0; s1_nan_q <= 1'b0; s1_inf_q <= 1'b0;
      s1_zero_q  <= 1'b0; s1_int64_q <= 1'b0; s1_uns_q <= 1'b0; s1_rm_q <= '0;
      s1_exp_q   <= '0;   s1_man_q <= '0;
      s2_valid_q <= 1'b0; s2_sign_q <= 1'b0; s2_nan_q <= 1'b0; s2_inf_q <= 1'b0;
      s2_ovf_q   <= 1'b0; s2_g_q <= 1'b0; s2_s_q <= 1'b0; s2_int64_q <= 1'b0;
      s2_uns_q   <= 1'b0; s2_rm_q <= '0; s2_mag_q <= '0;
      valid_o_q  <= 1'b0; int_out_q <= '0; fflags_q <= '0;
    end else if (adv) begin
      s1_valid_q <= valid_i;
      s1_sign_q  <= s1_sign_d;
      s1_nan_q   <= s1_nan_d;
      s1_inf_q   <= s1_inf_d;
      s1_zero_q  <= s1_zero_d;
      s1_int64_q <= int_fmt[0];
      s1_uns_q   <= fpu_op[4];
      s1_rm_q    <= rm;
      s1_exp_q   <= s1_exp_d;
      s1_man_q   <= s1_man_d;
      s2_valid_q <= s1_valid_q;
      s2_sign_q  <= s1_sign_q;
      s2_nan_q   <= s1_nan_q;
      s2_inf_q   <= s1_inf_q;
      s2_ovf_q   <= s2_ovf_d;
      s2_g_q     <= s2_g_d;
      s2_s_q     <= s2_s_d;
      s2_int64_q <= s1_int64_q;
      s2_uns_q   <= s1_uns_q;
      s2_rm_q    <= s1_rm_q;
      s2_mag_q   <= s2_mag_d;
      valid_o_q  <= s2_valid_q;
      int_out_q  <= int_out_d;
      fflags_q   <= fflags_d;
    end
  end

endmodule

// File: tb/tb_fpu_denormalise.sv
// Bench for fpu_denormalise: directed conversions, random backpressure, reset in flight.
module tb_fpu_denormalise;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        valid_i, ready_o, fp_fmt, valid_o, ready_i;
  logic [63:0] fp_in, int_out;
  logic [1:0]  int_fmt;
  logic [4:0]  fpu_op, fflags;
  logic [2:0]  rm;

  int n_cmp  = 0;
  int n_fail = 0;

  typedef struct {
    logic [63:0] fp;
    logic        fmt;
    logic        int64;
    logic        uns;
    logic [2:0]  rm;
    logic [63:0] res;
    logic [4:0]  flags;
  } vec_t;

  localparam int N_VEC = 17;
  vec_t vecs [N_VEC];
  logic [68:0] exp_q[$];

  fpu_denormalise dut (
    .clk(clk), .rst_n(rst_n), .valid_i(valid_i), .ready_o(ready_o),
    .fp_in(fp_in), .fp_fmt(fp_fmt), .int_fmt(int_fmt), .fpu_op(fpu_op), .rm(rm),
    .valid_o(valid_o), .ready_i(ready_i), .int_out(int_out), .fflags(fflags)
  );

  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  task automatic load_vectors();
    vecs[0]  = '{64'h4004_0000_0000_0000, 1'b1, 1'b0, 1'b0, 3'b000, 64'h2, 5'b00001};
    vecs[1]  = '{64'h4004_0000_0000_0000, 1'b1, 1'b0, 1'b0, 3'b100, 64'h3, 5'b00001};
    vecs[2]  = '{64'h4004_0000_0000_0000, 1'b1, 1'b0, 1'b0, 3'b011, 64'h3, 5'b00001};
    vecs[3]  = '{64'h4004_0000_0000_0000, 1'b1, 1'b0, 1'b0, 3'b010, 64'h2, 5'b00001};
    vecs[4]  = '{64'hBFF8_0000_0000_0000, 1'b1, 1'b1, 1'b1, 3'b001, 64'h0, 5'b10000};
    vecs[5]  = '{64'hBFE0_0000_0000_0000, 1'b1, 1'b1, 1'b1, 3'b001, 64'h0, 5'b00001};
    vecs[6]  = '{64'h0000_0000_4F00_0000, 1'b0, 1'b0, 1'b0, 3'b001, 64'h0000_0000_7FFF_FFFF, 5'b10000};
    vecs[7]  = '{64'h0000_0000_CF00_0000, 1'b0, 1'b0, 1'b0, 3'b001, 64'hFFFF_FFFF_8000_0000, 5'b00000};
    vecs[8]  = '{64'h7FF8_0000_0000_0000, 1'b1, 1'b1, 1'b0, 3'b000, 64'h7FFF_FFFF_FFFF_FFFF, 5'b10000};
    vecs[9]  = '{64'hFFF0_0000_0000_0000, 1'b1, 1'b0, 1'b1, 3'b001, 64'h0, 5'b10000};
    vecs[10] = '{64'h0000_0000_4F7F_FFFF, 1'b0, 1'b0, 1'b1, 3'b001, 64'hFFFF_FFFF_FFFF_FF00, 5'b00000};
    vecs[11] = '{64'h0000_0000_C030_0000, 1'b0, 1'b0, 1'b0, 3'b000, 64'hFFFF_FFFF_FFFF_FFFD, 5'b00001};
    vecs[12] = '{64'h0000_0000_8000_0000, 1'b0, 1'b0, 1'b1, 3'b010, 64'h0, 5'b00000};
    vecs[13] = '{64'h43E0_0000_0000_0000, 1'b1, 1'b1, 1'b1, 3'b001, 64'h8000_0000_0000_0000, 5'b00000};
    vecs[14] = '{64'h43F0_0000_0000_0000, 1'b1, 1'b1, 1'b1, 3'b001, 64'hFFFF_FFFF_FFFF_FFFF, 5'b10000};
    vecs[15] = '{64'h0000_0000_0000_0001, 1'b0, 1'b1, 1'b1, 3'b011, 64'h1, 5'b00001};
    vecs[16] = '{64'h400E_0000_0000_0000, 1'b1, 1'b0, 1'b0, 3'b101, 64'h3, 5'b00001};
  endtask

  // Ignored input bits get random values so a dependence on them shows up.
  task automatic drive_vec(input int k);
    fp_fmt  = vecs[k].fmt;
    fp_in   = vecs[k].fmt ? vecs[k].fp : {32'($urandom), vecs[k].fp[31:0]};
    int_fmt = {1'($urandom), vecs[k].int64};
    fpu_op  = {vecs[k].uns, 4'($urandom)};
    rm      = vecs[k].rm;
  endtask

  task automatic test_reset();
    rst_n = 1'b0; valid_i = 1'b0; ready_i = 1'b0;
    drive_vec(0);
    repeat (3) @(posedge clk);
    @(negedge clk);
    n_cmp++; if (valid_o !== 1'b0)  begin n_fail++; $display("FAIL reset_valid_o: got %b want 0", valid_o); end
    n_cmp++; if (int_out !== 64'h0) begin n_fail++; $display("FAIL reset_int_out: got %h want 0", int_out); end
    n_cmp++; if (fflags !== 5'h0)   begin n_fail++; $display("FAIL reset_fflags: got %b want 0", fflags); end
    n_cmp++; if (ready_o !== 1'b1)  begin n_fail++; $display("FAIL reset_ready_o: got %b want 1", ready_o); end
    rst_n = 1'b1;
    @(posedge clk); #1;
  endtask

  task automatic test_vectors();
    for (int k = 0; k < N_VEC; k++) begin
      bit got;
      logic [68:0] e;
      drive_vec(k);
      valid_i = 1'b1; ready_i = 1'b1;
      @(negedge clk);
      if (valid_i && ready_o) exp_q.push_back({vecs[k].flags, vecs[k].res});
      @(posedge clk); #1;
      valid_i = 1'b0;
      got = 1'b0;
      for (int c = 0; c < 8 && !got; c++) begin
        @(negedge clk);
        if (valid_o && ready_i) begin
          got = 1'b1;
          n_cmp++;
          if (exp_q.size() == 0) begin
            n_fail++; $display("FAIL vec%0d unexpected output int=%h", k, int_out);
          end else begin
            e = exp_q.pop_front();
            if ({fflags, int_out} !== e) begin
              n_fail++;
              $display("FAIL vec%0d: got int=%h flags=%b, want int=%h flags=%b",
                       k, int_out, fflags, e[63:0], e[68:64]);
            end
          end
        end
        @(posedge clk); #1;
      end
      if (!got) begin
        n_cmp++; n_fail++;
        $display("FAIL vec%0d timeout: got no valid_o, want int=%h", k, vecs[k].res);
      end
    end
  endtask

  task automatic test_back_to_back();
    int sel [8];
    int sent = 0;
    int got = 0;
    bit prev_stall = 1'b0;
    logic [63:0] held_int;
    logic [4:0]  held_flags;
    logic [68:0] e;
    for (int i = 0; i < 8; i++) sel[i] = $urandom_range(0, N_VEC - 1);
    drive_vec(sel[0]);
    valid_i = 1'b1;
    ready_i = 1'($urandom_range(0, 1));
    for (int c = 0; c < 300 && got < 8; c++) begin
      @(negedge clk);
      n_cmp++;
      if (ready_o !== !(valid_o && !ready_i)) begin
        n_fail++; $display("FAIL b2b_ready_o: got %b with valid_o=%b ready_i=%b", ready_o, valid_o, ready_i);
      end
      if (prev_stall) begin
        n_cmp++;
        if (valid_o !== 1'b1 || int_out !== held_int || fflags !== held_flags) begin
          n_fail++;
          $display("FAIL b2b_hold: got v=%b int=%h flags=%b, want v=1 int=%h flags=%b",
                   valid_o, int_out, fflags, held_int, held_flags);
        end
      end
      if (valid_o && ready_i) begin
        n_cmp++;
        if (exp_q.size() == 0) begin
          n_fail++; $display("FAIL b2b_extra: unexpected output int=%h", int_out);
        end else begin
          e = exp_q.pop_front();
          if ({fflags, int_out} !== e) begin
            n_fail++;
            $display("FAIL b2b_out%0d: got int=%h flags=%b, want int=%h flags=%b",
                     got, int_out, fflags, e[63:0], e[68:64]);
          end
        end
        got++;
      end
      prev_stall = valid_o && !ready_i;
      held_int   = int_out;
      held_flags = fflags;
      if (valid_i && ready_o) begin
        exp_q.push_back({vecs[sel[sent]].flags, vecs[sel[sent]].res});
        sent++;
      end
      @(posedge clk); #1;
      ready_i = 1'($urandom_range(0, 1));
      if (sent < 8) begin
        drive_vec(sel[sent]);
        valid_i = 1'b1;
      end else begin
        valid_i = 1'b0;
      end
    end
    if (got < 8) begin
      n_cmp++; n_fail++; $display("FAIL b2b_timeout: got %0d outputs want 8", got);
    end
    valid_i = 1'b0; ready_i = 1'b1;
    @(posedge clk); #1;
  endtask

  task automatic test_reset_midstream();
    int stale = 0;
    ready_i = 1'b0;
    for (int i = 0; i < 3; i++) begin
      drive_vec(i + 4);
      valid_i = 1'b1;
      @(posedge clk); #1;
    end
    valid_i = 1'b0;
    n_cmp++; if (valid_o !== 1'b1) begin n_fail++; $display("FAIL mid_fill: valid_o got %b want 1", valid_o); end
    #2 rst_n = 1'b0;
    #1;
    n_cmp++; if (valid_o !== 1'b0) begin n_fail++; $display("FAIL mid_async_valid: got %b want 0", valid_o); end
    n_cmp++;
    if (int_out !== 64'h0 || fflags !== 5'h0) begin
      n_fail++; $display("FAIL mid_async_data: got int=%h flags=%b want 0", int_out, fflags);
    end
    exp_q.delete();
    @(negedge clk);
    rst_n = 1'b1; ready_i = 1'b1;
    repeat (6) begin
      @(negedge clk);
      if (valid_o) stale++;
    end
    n_cmp++; if (stale != 0) begin n_fail++; $display("FAIL mid_stale: got %0d stale outputs want 0", stale); end
    @(posedge clk); #1;
    drive_vec(11);
    valid_i = 1'b1;
    @(posedge clk); #1;
    valid_i = 1'b0;
    n_cmp++; if (valid_o !== 1'b0) begin n_fail++; $display("FAIL mid_lat1: valid_o got %b want 0", valid_o); end
    @(posedge clk); #1;
    n_cmp++; if (valid_o !== 1'b0) begin n_fail++; $display("FAIL mid_lat2: valid_o got %b want 0", valid_o); end
    @(posedge clk); #1;
    n_cmp++;
    if (valid_o !== 1'b1 || int_out !== vecs[11].res || fflags !== vecs[11].flags) begin
      n_fail++;
      $display("FAIL mid_lat3: got v=%b int=%h flags=%b, want v=1 int=%h flags=%b",
               valid_o, int_out, fflags, vecs[11].res, vecs[11].flags);
    end
    @(posedge clk); #1;
  endtask

  initial begin
    load_vectors();
    test_reset();
    test_vectors();
    test_back_to_back();
    test_reset_midstream();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
